// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core. One memory port is shared by fetch and
// load/store; every datapath control is decoded from the state, the opcode and the memory handshake.
module multicycle_controller #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          Opcode,
    input  logic                BrTaken,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [1:0]          PCSrc,
    output logic                ALUSrc,
    output logic [1:0]          ALUOp,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                Branch,
    output logic                jal,
    output logic                jalr,
    output logic                illegal,
    output logic                instr_retired,
    output logic [RETIRE_W-1:0] instret,
    output logic [2:0]          dbg_state
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t              state;
    state_t              state_next;
    logic [RETIRE_W-1:0] retire_cnt;

    logic is_r, is_i, is_lw, is_sw, is_br, is_lui, is_jal, is_jalr, is_legal;
    logic       exec_alusrc;
    logic [1:0] exec_aluop;

    assign is_r     = (Opcode == OP_R);
    assign is_i     = (Opcode == OP_I);
    assign is_lw    = (Opcode == OP_LW);
    assign is_sw    = (Opcode == OP_SW);
    assign is_br    = (Opcode == OP_BR);
    assign is_lui   = (Opcode == OP_LUI);
    assign is_jal   = (Opcode == OP_JAL);
    assign is_jalr  = (Opcode == OP_JALR);
    assign is_legal = is_r | is_i | is_lw | is_sw | is_br | is_lui | is_jal | is_jalr;

    // ALU controls chosen in EXEC and held through MEM/WB while the IR is stable.
    always_comb begin
        exec_alusrc = is_lw | is_sw | is_i | is_lui;
        if (is_lw || is_sw)     exec_aluop = 2'b00;
        else if (is_br)         exec_aluop = 2'b01;
        else if (is_r || is_i)  exec_aluop = 2'b10;
        else                    exec_aluop = 2'b11;
    end

    always_comb begin
        state_next    = state;
        mem_req       = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        PCSrc         = 2'b00;
        ALUSrc        = 1'b0;
        ALUOp         = 2'b00;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        Branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        illegal       = 1'b0;
        instr_retired = 1'b0;
        // Reset gates every output so an in-flight memory access is dropped at once.
        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite    = 1'b1;
                        PCWrite    = 1'b1;
                        state_next = DECODE;
                    end
                end
                DECODE: state_next = is_legal ? EXEC : TRAP;
                EXEC: begin
                    ALUSrc = exec_alusrc;
                    ALUOp  = exec_aluop;
                    jal    = is_jal;
                    jalr   = is_jalr;
                    if (is_br) begin
                        Branch        = 1'b1;
                        PCSrc         = 2'b01;
                        PCWrite       = BrTaken;
                        instr_retired = 1'b1;
                        state_next    = FETCH;
                    end else if (is_lw || is_sw) begin
                        state_next = MEM;
                    end else begin
                        state_next = WB;
                    end
                end
                MEM: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemRead  = is_lw;
                    MemWrite = is_sw;
                    ALUSrc   = 1'b1;
                    if (mem_ready) begin
                        instr_retired = is_sw;
                        state_next    = is_sw ? FETCH : WB;
                    end
                end
                WB: begin
                    ALUSrc        = exec_alusrc;
                    ALUOp         = exec_aluop;
                    jal           = is_jal;
                    jalr          = is_jalr;
                    RegWrite      = 1'b1;
                    MemtoReg      = is_lw;
                    instr_retired = 1'b1;
                    if (is_jal) begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'b01;
                    end else if (is_jalr) begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'b10;
                    end
                    state_next = FETCH;
                end
                TRAP:    illegal = 1'b1;
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            retire_cnt <= '0;
        end else begin
            state <= state_next;
            if (instr_retired) retire_cnt <= retire_cnt + RETIRE_W'(1);
        end
    end

    assign instret   = rst_n ? retire_cnt : '0;
    assign dbg_state = rst_n ? state : FETCH;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-feature tasks drive instructions through a memory
// model and compare state sequences, strobes, latencies and the retire counter.
module tb_multicycle_controller;
  localparam int RW = 4;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_TRAP = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] Opcode = 7'd0;
  logic BrTaken = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite;
  logic Branch, jal, jalr, illegal, instr_retired;
  logic [1:0] PCSrc, ALUOp;
  logic [RW-1:0] instret;
  logic [2:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [RW-1:0] exp_instret = '0;

  logic [2:0] log_state [0:63];
  logic [1:0] log_pcsrc [0:63];
  logic [1:0] log_aluop [0:63];
  logic log_regw [0:63];
  logic log_pcw [0:63];
  logic log_iord [0:63];
  logic log_memr [0:63];
  logic log_memw [0:63];
  logic log_mtr [0:63];
  logic log_alusrc [0:63];
  logic log_branch [0:63];
  logic [RW-1:0] log_instret [0:63];

  multicycle_controller #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .BrTaken(BrTaken), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Branch(Branch), .jal(jal), .jalr(jalr),
    .illegal(illegal), .instr_retired(instr_retired), .instret(instret),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_instret = '0;
  endtask

  function automatic int exp_cycles(input logic [6:0] op, input int fw, input int mw);
    int base;
    base = (op == OP_BR) ? 3 : (op == OP_LW) ? 5 : 4;
    if (op == OP_LW || op == OP_SW) base += mw;
    return base + fw;
  endfunction

  // Driver: called at a falling edge with the DUT in FETCH; returns at a falling edge.
  // The memory model inserts fw wait cycles on fetch and mw on the data access.
  task automatic drive_instr(input logic [6:0] op, input logic br, input int fw, input int mw,
                             input int max_cyc, output int cycles, output bit retired);
    int fc, mc;
    fc = 0; mc = 0; cycles = 0; retired = 1'b0;
    Opcode = op;
    BrTaken = br;
    while (!retired && cycles < max_cyc) begin
      #1;
      if (mem_req && !IorD) begin
        mem_ready = (fc >= fw); fc++;
      end else if (mem_req && IorD) begin
        mem_ready = (mc >= mw); mc++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      log_state[cycles] = dbg_state;   log_pcsrc[cycles] = PCSrc;
      log_aluop[cycles] = ALUOp;       log_regw[cycles] = RegWrite;
      log_pcw[cycles] = PCWrite;       log_iord[cycles] = IorD;
      log_memr[cycles] = MemRead;      log_memw[cycles] = MemWrite;
      log_mtr[cycles] = MemtoReg;      log_alusrc[cycles] = ALUSrc;
      log_branch[cycles] = Branch;     log_instret[cycles] = instret;
      retired = instr_retired;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; Opcode = OP_R;
    repeat (2) begin
      @(negedge clk); #1;
      tests_run++;
      if ({mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrc, ALUOp, MemtoReg,
           RegWrite, Branch, jal, jalr, illegal, instr_retired, instret} !== '0) begin
        tests_failed++;
        $display("FAIL reset_outputs: got mem_req=%b IorD=%b MemRead=%b illegal=%b instret=%0d, all required 0",
                 mem_req, IorD, MemRead, illegal, instret);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({mem_req, IorD, MemRead, dbg_state} !== {1'b1, 1'b0, 1'b1, S_FETCH}) begin
      tests_failed++;
      $display("FAIL reset_release: got mem_req=%b IorD=%b MemRead=%b state=%0d, required 1 0 1 0",
               mem_req, IorD, MemRead, dbg_state);
    end
    apply_reset();
  endtask

  task automatic test_add();
    int cyc; bit ret; logic [7:0] e;
    exp_q.push_back(8'(exp_cycles(OP_R, 0, 0)));
    drive_instr(OP_R, 1'b0, 0, 0, 32, cyc, ret);
    exp_instret++;
    e = exp_q.pop_front();
    tests_run++;
    if (cyc !== int'(e) || !ret) begin
      tests_failed++;
      $display("FAIL add_latency: got %0d cycles (retired=%b), required %0d", cyc, ret, e);
    end
    tests_run++;
    if ({log_state[0], log_state[1], log_state[2], log_state[3]} !== {S_FETCH, S_DECODE, S_EXEC, S_WB}) begin
      tests_failed++;
      $display("FAIL add_states: got %0d %0d %0d %0d, required 0 1 2 4",
               log_state[0], log_state[1], log_state[2], log_state[3]);
    end
    tests_run++;
    if ({log_regw[0], log_regw[1], log_regw[2], log_regw[3], log_aluop[2]} !== 6'b0001_10) begin
      tests_failed++;
      $display("FAIL add_regwrite_aluop: got regw=%b%b%b%b aluop=%b, required 0001 10",
               log_regw[0], log_regw[1], log_regw[2], log_regw[3], log_aluop[2]);
    end
    tests_run++;
    if (log_instret[3] !== RW'(0) || instret !== exp_instret) begin
      tests_failed++;
      $display("FAIL add_instret: got %0d in WB and %0d after, required 0 then %0d",
               log_instret[3], instret, exp_instret);
    end
  endtask

  task automatic test_lw_wait();
    int cyc, mem_cyc; bit ret; logic [7:0] e;
    exp_q.push_back(8'(exp_cycles(OP_LW, 0, 3)));
    drive_instr(OP_LW, 1'b0, 0, 3, 32, cyc, ret);
    exp_instret++;
    e = exp_q.pop_front();
    tests_run++;
    if (cyc !== int'(e) || !ret) begin
      tests_failed++;
      $display("FAIL lw_latency: got %0d cycles, required %0d", cyc, e);
    end
    mem_cyc = 0;
    for (int i = 0; i < cyc; i++) if (log_iord[i] && log_memr[i]) mem_cyc++;
    tests_run++;
    if (mem_cyc !== 4) begin
      tests_failed++;
      $display("FAIL lw_mem_hold: got %0d cycles with IorD&MemRead, required 4", mem_cyc);
    end
    tests_run++;
    if ({log_state[cyc-1], log_mtr[cyc-1], log_regw[cyc-1]} !== {S_WB, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL lw_wb: got state=%0d MemtoReg=%b RegWrite=%b, required 4 1 1",
               log_state[cyc-1], log_mtr[cyc-1], log_regw[cyc-1]);
    end
    tests_run++;
    if (instret !== exp_instret) begin
      tests_failed++;
      $display("FAIL lw_instret: got %0d, required %0d", instret, exp_instret);
    end
  endtask

  task automatic test_branch();
    int cyc; bit ret; logic [7:0] e;
    for (int b = 0; b < 2; b++) begin
      exp_q.push_back(8'(exp_cycles(OP_BR, 0, 0)));
      drive_instr(OP_BR, 1'(b), 0, 0, 32, cyc, ret);
      exp_instret++;
      e = exp_q.pop_front();
      tests_run++;
      if (cyc !== int'(e) || !ret) begin
        tests_failed++;
        $display("FAIL br%0d_latency: got %0d cycles, required %0d", b, cyc, e);
      end
      tests_run++;
      if ({log_branch[2], log_pcw[2], log_pcsrc[2], log_aluop[2]} !== {1'b1, 1'(b), 2'b01, 2'b01}) begin
        tests_failed++;
        $display("FAIL br%0d_ctrl: got Branch=%b PCWrite=%b PCSrc=%b ALUOp=%b, required 1 %0d 01 01",
                 b, log_branch[2], log_pcw[2], log_pcsrc[2], log_aluop[2], b);
      end
      tests_run++;
      if (instret !== exp_instret) begin
        tests_failed++;
        $display("FAIL br%0d_instret: got %0d, required %0d", b, instret, exp_instret);
      end
    end
  endtask

  task automatic test_jumps();
    logic [6:0] ops [0:3];
    logic [5:0] want [0:3];
    int cyc; bit ret; logic [7:0] e;
    ops[0] = OP_JAL;  want[0] = {1'b1, 2'b01, 2'b11, 1'b0};
    ops[1] = OP_JALR; want[1] = {1'b1, 2'b10, 2'b11, 1'b0};
    ops[2] = OP_LUI;  want[2] = {1'b0, 2'b00, 2'b11, 1'b1};
    ops[3] = OP_I;    want[3] = {1'b0, 2'b00, 2'b10, 1'b1};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(exp_cycles(ops[i], i, 0)));
      drive_instr(ops[i], 1'b0, i, 0, 32, cyc, ret);
      exp_instret++;
      e = exp_q.pop_front();
      tests_run++;
      if (cyc !== int'(e) || !ret) begin
        tests_failed++;
        $display("FAIL wb_op%0d_latency: got %0d cycles, required %0d", i, cyc, e);
      end
      tests_run++;
      if ({log_pcw[cyc-1], log_pcsrc[cyc-1], log_aluop[cyc-1], log_alusrc[cyc-1]} !== want[i]) begin
        tests_failed++;
        $display("FAIL wb_op%0d_ctrl: got PCWrite/PCSrc/ALUOp/ALUSrc=%b, required %b", i,
                 {log_pcw[cyc-1], log_pcsrc[cyc-1], log_aluop[cyc-1], log_alusrc[cyc-1]}, want[i]);
      end
    end
  endtask

  task automatic test_sw();
    int cyc; bit ret; logic [7:0] e;
    exp_q.push_back(8'(exp_cycles(OP_SW, 0, 2)));
    drive_instr(OP_SW, 1'b0, 0, 2, 32, cyc, ret);
    exp_instret++;
    e = exp_q.pop_front();
    tests_run++;
    if (cyc !== int'(e) || !ret) begin
      tests_failed++;
      $display("FAIL sw_latency: got %0d cycles, required %0d", cyc, e);
    end
    tests_run++;
    if ({log_state[cyc-1], log_memw[cyc-1], log_memr[cyc-1], log_iord[cyc-1]} !== {S_MEM, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL sw_mem: got state=%0d MemWrite=%b MemRead=%b IorD=%b, required 3 1 0 1",
               log_state[cyc-1], log_memw[cyc-1], log_memr[cyc-1], log_iord[cyc-1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [0:7];
    int cyc, fw, mw; bit ret; logic [6:0] op; logic [7:0] e;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LW; ops[3] = OP_SW;
    ops[4] = OP_BR; ops[5] = OP_LUI; ops[6] = OP_JAL; ops[7] = OP_JALR;
    for (int n = 0; n < 12; n++) begin
      op = ops[$urandom_range(0, 7)];
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      exp_q.push_back(8'(exp_cycles(op, fw, mw)));
      drive_instr(op, 1'($urandom_range(0, 1)), fw, mw, 32, cyc, ret);
      exp_instret++;
      e = exp_q.pop_front();
      tests_run++;
      if (cyc !== int'(e) || !ret || instret !== exp_instret) begin
        tests_failed++;
        $display("FAIL b2b_%0d op=%b: got %0d cycles instret=%0d, required %0d cycles instret=%0d",
                 n, op, cyc, instret, e, exp_instret);
      end
    end
  endtask

  task automatic test_trap();
    int cyc; bit ret;
    drive_instr(7'b1111111, 1'b0, 0, 0, 6, cyc, ret);
    tests_run++;
    if (ret || log_state[1] !== S_DECODE || log_state[2] !== S_TRAP) begin
      tests_failed++;
      $display("FAIL trap_entry: got retired=%b states %0d %0d, required 0 and 1 5",
               ret, log_state[1], log_state[2]);
    end
    repeat (3) begin
      #1; mem_ready = 1'($urandom_range(0, 1)); #1;
      tests_run++;
      if ({illegal, mem_req, instr_retired, dbg_state} !== {1'b1, 1'b0, 1'b0, S_TRAP}) begin
        tests_failed++;
        $display("FAIL trap_hold: got illegal=%b mem_req=%b retired=%b state=%0d, required 1 0 0 5",
                 illegal, mem_req, instr_retired, dbg_state);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL trap_reset_clear: got illegal=%b, required 0", illegal);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    tests_run++;
    if ({mem_req, IorD, illegal, dbg_state} !== {1'b1, 1'b0, 1'b0, S_FETCH}) begin
      tests_failed++;
      $display("FAIL trap_restart: got mem_req=%b IorD=%b illegal=%b state=%0d, required 1 0 0 0",
               mem_req, IorD, illegal, dbg_state);
    end
    apply_reset();
  endtask

  task automatic test_wrap();
    int cyc; bit ret;
    apply_reset();
    for (int n = 0; n < 16; n++) begin
      drive_instr(OP_R, 1'b0, 0, 0, 32, cyc, ret);
      exp_instret++;
      tests_run++;
      if (instret !== exp_instret) begin
        tests_failed++;
        $display("FAIL wrap_count_%0d: got %0d, required %0d", n, instret, exp_instret);
      end
    end
    tests_run++;
    if (instret !== RW'(0)) begin
      tests_failed++;
      $display("FAIL wrap_zero: got %0d after 16 retires, required 0", instret);
    end
  endtask

  task automatic test_mid_reset();
    int cyc; bit ret;
    apply_reset();
    drive_instr(OP_R, 1'b0, 0, 0, 32, cyc, ret);
    drive_instr(OP_SW, 1'b0, 0, 100, 6, cyc, ret);
    tests_run++;
    if (ret || dbg_state !== S_MEM || log_memw[5] !== 1'b1 || instret !== RW'(1)) begin
      tests_failed++;
      $display("FAIL midrst_wait: got retired=%b state=%0d MemWrite=%b instret=%0d, required 0 3 1 1",
               ret, dbg_state, log_memw[5], instret);
    end
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    tests_run++;
    if ({mem_req, MemWrite, IorD, instr_retired} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midrst_drop: got mem_req=%b MemWrite=%b IorD=%b retired=%b, required 0000",
               mem_req, MemWrite, IorD, instr_retired);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    tests_run++;
    if ({dbg_state, mem_req, IorD, MemWrite, instret} !== {S_FETCH, 1'b1, 1'b0, 1'b0, RW'(0)}) begin
      tests_failed++;
      $display("FAIL midrst_restart: got state=%0d mem_req=%b IorD=%b MemWrite=%b instret=%0d, required 0 1 0 0 0",
               dbg_state, mem_req, IorD, MemWrite, instret);
    end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jumps();
    test_sw();
    test_back_to_back();
    test_trap();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control FSM for the multicycle RV32I core variant. It replaces the single-cycle decoder with a state machine that shares one memory port between instruction fetch and load/store, and it waits on a variable-latency memory handshake. It drives the datapath's PC, instruction-register, ALU, register-file and memory controls from `Opcode` and the current state. It also counts retired instructions.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `Opcode` input 7: opcode field from the instruction register. Valid from DECODE onward; ignored in FETCH.
- `BrTaken` input 1: branch-comparison result from the ALU, sampled in EXEC.
- `mem_ready` input 1: memory completion for the current `mem_req`.
- `mem_req` output 1: memory access request.
- `IorD` output 1: memory address select (0 = PC, 1 = ALU result).
- `MemRead` output 1: memory read strobe.
- `MemWrite` output 1: memory write strobe.
- `IRWrite` output 1: load the instruction register and OldPC.
- `PCWrite` output 1: load the PC.
- `PCSrc` output 2: next-PC select (00 = PC+4, 01 = OldPC+imm, 10 = ALU result & ~1).
- `ALUSrc` output 1: 1 selects the immediate as the second ALU operand.
- `ALUOp` output 2: 00 = LW/SW, 01 = BR, 10 = R/I-type, 11 = LUI/JAL/JALR.
- `MemtoReg` output 1: write-back from memory.
- `RegWrite` output 1: register-file write enable.
- `Branch` output 1: a conditional branch is being evaluated.
- `jal` output 1: the current instruction is JAL.
- `jalr` output 1: the current instruction is JALR.
- `illegal` output 1: sticky unsupported-opcode flag.
- `instr_retired` output 1: one-cycle pulse marking the final cycle of an instruction.
- `instret` output `RETIRE_W`: count of retired instructions.

## Operation
- **Supported opcodes:**
  - R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, LUI 0110111, JAL 1101111, JALR 1100111.
  - Any other value is illegal.
- **States:** FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **Output generation:**
  - Outputs are combinational from the state, `Opcode`, `BrTaken` and `mem_ready`.
  - Every output not listed for a state is 0.
- **FETCH:**
  - Asserts `mem_req=1`, `MemRead=1`, `IorD=0`.
  - On `mem_ready=1`: `IRWrite=1`, `PCWrite=1`, `PCSrc=00`, then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE:**
  - One cycle with no strobes.
  - Illegal opcode: go to TRAP.
  - Otherwise go to EXEC.
- **EXEC:**
  - `ALUSrc=1` for LW/SW/I/LUI. `ALUOp` follows the encoding above. `jal`/`jalr` reflect the opcode.
  - BR: `Branch=1`, `PCSrc=01`, `PCWrite=BrTaken`, `instr_retired=1`, then go to FETCH.
  - LW/SW: go to MEM.
  - Others: go to WB.
- **MEM:**
  - Asserts `mem_req=1`, `IorD=1`, `MemRead=1` for LW or `MemWrite=1` for SW. `ALUSrc=1` and `ALUOp=00` are held.
  - No `mem_ready`: stay in MEM.
  - `mem_ready` with SW: `instr_retired=1`, then go to FETCH.
  - `mem_ready` with LW: go to WB.
- **WB:**
  - `RegWrite=1`, `MemtoReg=1` for LW only. The EXEC ALU controls are held.
  - JAL: `PCWrite=1`, `PCSrc=01`.
  - JALR: `PCWrite=1`, `PCSrc=10`.
  - `instr_retired=1`, then go to FETCH.
- **TRAP:**
  - `illegal=1` and all other outputs 0.
  - Only reset exits TRAP.
- **`instret`:**
  - Increments by 1 on every clock edge where `instr_retired=1`.
  - Wraps from all-ones to 0.
- **Memory handshake:**
  - While `mem_req=1`, the address select and strobes stay stable until `mem_ready=1`.
  - `mem_ready` is ignored when `mem_req=0`.
  - `mem_ready` may be high in the same cycle the request is first asserted (zero-wait access).

## Timing
- **Reset:**
  - While `rst_n=0`, all outputs are 0, including `illegal` and `mem_req`.
  - At a clock edge with `rst_n=0`: state goes to FETCH and `instret` goes to 0.
  - The first cycle after release is FETCH with `mem_req=1`.
- **Reset mid-operation:**
  - Reset during MEM or FETCH drops `mem_req` combinationally. The access is abandoned and no retire is counted.
  - Reset in TRAP clears `illegal`.
- **Latency with zero-wait memory (cycles per instruction):**
  - R, I, LUI, JAL, JALR: 4.
  - LW: 5.
  - SW: 4.
  - BR: 3, taken or not.
- **Wait states:** each memory wait cycle adds 1 cycle to FETCH or MEM.
- **Mealy outputs:**
  - `IRWrite` and `PCWrite` in FETCH, and `instr_retired` in MEM, are asserted only in the cycle `mem_ready=1`.
- **`instret` timing:** `instret` reflects a retire one cycle after the `instr_retired` pulse.

## Test plan
- **Reset:** `rst_n=0` for 2 cycles, then release with `mem_ready` tied high.
  - All outputs 0 during reset.
  - Cycle 1 after release: `mem_req=1`, `IorD=0`.
- **ADD (0110011) with zero-wait memory:**
  - State sequence FETCH, DECODE, EXEC, WB.
  - `RegWrite=1` only in WB, `ALUOp=10`.
  - `instret` goes 0 to 1 one cycle after WB.
- **LW with 3 wait cycles in MEM:**
  - MEM holds `IorD=1`, `MemRead=1` for 4 cycles.
  - WB has `MemtoReg=1`.
  - Total 8 cycles.
- **BEQ with `BrTaken=0`, then BEQ with `BrTaken=1`:**
  - `PCWrite` is 0 for the first and 1 for the second, both with `PCSrc=01`.
  - Each retires in 3 cycles.
- **Opcode 1111111:**
  - DECODE goes to TRAP, `illegal=1`, `mem_req=0` indefinitely.
  - `rst_n=0` clears `illegal` and restarts at FETCH.
- **Wrap and mid-access reset:**
  - With `RETIRE_W=4`, 16 retires bring `instret` back to 0.
  - Asserting `rst_n=0` during a SW wait in MEM gives `MemWrite=0` immediately and no increment.
